// File: rtl/skinny_pkg.sv
// ---------------------------------------------------------------------------
// skinny_pkg
//
// Shared constants and types for the SKINNY-64 S-box layer.
//
// Contents:
//   sbox_layer_state_t  control state of the S-box layer (IDLE, BUSY, DONE)
//   SKINNY_SBOX4        forward 4-bit S-box, indexed by the input nibble
//   SKINNY_SBOX4_INV    inverse 4-bit S-box, indexed by the input nibble
//   skinny_sbox4()      single-nibble lookup with forward/inverse select
// ---------------------------------------------------------------------------
package skinny_pkg;

    // IDLE: waiting for a state, BUSY: substituting one group of lanes per
    // cycle, DONE: presenting the finished state until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sbox_layer_state_t;

    // Element x holds S(x).
    localparam logic [3:0] SKINNY_SBOX4 [16] = '{
        4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
        4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
    };

    // Element x holds S^-1(x).
    localparam logic [3:0] SKINNY_SBOX4_INV [16] = '{
        4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
        4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
    };

    // Single-nibble substitution; inv selects the inverse table.
    function automatic logic [3:0] skinny_sbox4(input logic [3:0] x, input logic inv);
        return inv ? SKINNY_SBOX4_INV[x] : SKINNY_SBOX4[x];
    endfunction

endpackage

// File: rtl/skinny_sbox4_lut.sv
// ---------------------------------------------------------------------------
// skinny_sbox4_lut
//
// Purely combinational 4-bit SKINNY S-box with forward/inverse select.
// Deliberately holds no state so that a masked implementation can be dropped
// in as a replacement without touching the surrounding control logic.
//
// Ports:
//   x    in   4   input nibble
//   inv  in   1   0 = forward S-box, 1 = inverse S-box
//   y    out  4   substituted nibble
// ---------------------------------------------------------------------------
module skinny_sbox4_lut
    import skinny_pkg::*;
(
    input  logic [3:0] x,
    input  logic       inv,
    output logic [3:0] y
);

    assign y = skinny_sbox4(x, inv);

endmodule

// File: rtl/skinny_sbox_layer.sv
// ---------------------------------------------------------------------------
// skinny_sbox_layer
//
// SKINNY-64 S-box layer. Applies the 4-bit S-box (or its inverse) to every
// nibble of a NIBBLES*4-bit state, LANES nibbles per clock, so one state takes
// NIBBLES/LANES cycles. A smaller LANES means fewer S-box instances at the
// cost of latency, which is what makes masked variants affordable.
//
// The state is held in a rotating register. Each busy cycle the low LANES
// nibbles go through the S-boxes, and the results are written into the top
// LANES nibble positions while everything else shifts down by LANES nibbles.
// After NIBBLES/LANES beats every nibble is back in its original position.
//
// Parameters:
//   NIBBLES    state width in nibbles (state = 4*NIBBLES bits)
//   LANES      S-box instances / nibbles substituted per cycle
//              (NIBBLES must be a multiple of LANES)
//
// Ports:
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   in_state   in   4*NIBBLES   input state, nibble i = bits [4i+3:4i]
//   in_inv     in   1           0 = forward, 1 = inverse; sampled at accept
//   in_valid   in   1           input state valid
//   in_ready   out  1           block can accept a state
//   out_state  out  4*NIBBLES   substituted state, zero unless out_valid
//   out_valid  out  1           out_state valid
//   out_ready  in   1           consumer accepts out_state
// ---------------------------------------------------------------------------
module skinny_sbox_layer
    import skinny_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int LANES   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NIBBLES-1:0] in_state,
    input  logic                 in_inv,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*NIBBLES-1:0] out_state,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W     = 4 * NIBBLES;
    localparam int LW    = 4 * LANES;
    localparam int BEATS = NIBBLES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    // The rotation only returns every nibble home if the lanes tile the
    // state exactly, so reject any other configuration at elaboration.
    generate
        if ((LANES < 1) || (NIBBLES < 1) || (NIBBLES % LANES != 0)) begin : g_bad_config
            $error("skinny_sbox_layer: NIBBLES must be a positive multiple of LANES");
        end
    endgenerate

    sbox_layer_state_t state_q;
    sbox_layer_state_t state_d;

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  data_q;
    logic          inv_q;

    logic [LW-1:0] sub_out;
    logic [W-1:0]  rotated;
    logic          accept;
    logic          last_beat;

    assign accept    = in_valid & in_ready;
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    // One S-box per lane, always looking at the lowest LANES nibbles of the
    // working register. The mode comes from the register latched at accept,
    // so in_inv can change freely while a state is in flight.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            skinny_sbox4_lut u_lut (
                .x   (data_q[4*g +: 4]),
                .inv (inv_q),
                .y   (sub_out[4*g +: 4])
            );
        end
    endgenerate

    // Next value of the working register during a beat: substituted nibbles
    // enter at the top, the rest move down by LANES nibbles. With a fully
    // parallel layer there is nothing to rotate, the result is just sub_out.
    generate
        if (LANES == NIBBLES) begin : g_parallel
            assign rotated = sub_out;
        end else begin : g_serial
            assign rotated = {sub_out, data_q[W-1:LW]};
        end
    endgenerate

    // State register. Reset is asynchronous so an abort in the middle of a
    // state drops it immediately rather than on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A new state may be accepted in the same cycle the
    // previous result is taken, so DONE can go straight back to BUSY.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = accept ? BUSY : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. in_ready looks through to out_ready in DONE so a
    // back-to-back stream has no idle bubble between states. The working
    // register is only shown in DONE; the half-rotated state never leaks.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_state = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                in_ready = 1'b0;
            end
            DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
                out_state = data_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, otherwise rotate-and-substitute once per
    // busy cycle. The beat counter wraps harmlessly after the last beat
    // because it is cleared again on the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            inv_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= in_state;
            inv_q  <= in_inv;
            cnt_q  <= '0;
        end else if (state_q == BUSY) begin
            data_q <= rotated;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule
